serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
// - Parallel-to-serial frame transmitter. Accepts a WIDTH-bit word via valid/ready handshake.
// - Drives it onto a single-bit serial line, one bit per CLKS_PER_BIT clocks.
// - Serial line is the data input of downstream D flip-flop / shift-register receive stages.
// - Frame: start bit (0), WIDTH data bits LSB-first, optional even parity bit, STOP_BITS stop bits (1).
// PARAMETERS
// - WIDTH        8  data bits per frame (2..16)
// - CLKS_PER_BIT 2  clocks each serial bit is held (1..255)
// - PARITY_EN    1  1: append even-parity bit after data; 0: no parity bit
// - STOP_BITS    1  number of stop bits (1 or 2)
// PORTS
// - clock       in   1      rising-edge system clock
// - reset       in   1      synchronous, active-high reset
// - tx_data     in   WIDTH  word to send; sampled only on acceptance
// - tx_valid    in   1      word on tx_data is valid
// - tx_ready    out  1      block can accept a word (high only in IDLE)
// - serial_out  out  1      serial line; idle level 1
// - busy        out  1      frame in progress (START..STOP)
// - done        out  1      1-cycle pulse: frame's last stop bit completed
// BEHAVIOUR
// - Reset (clock edge with reset=1): state=IDLE, serial_out=1, tx_ready=1, busy=0, done=0.
//   - Bit counter and shift register cleared. Reset overrides every other input.
// - Acceptance: rising edge with tx_valid=1 and tx_ready=1.
//   - tx_data copied to shift register.
//   - Parity computed from the same copy.
//   - Next state START.
// - Latency: serial_out=0 starting the cycle after acceptance.
// - FSM states (all outputs registered):
//   - IDLE   serial_out=1, tx_ready=1, busy=0. Acceptance -> START.
//   - START  serial_out=0 for CLKS_PER_BIT clocks -> DATA.
//   - DATA   serial_out=shreg[0]. Shift right every CLKS_PER_BIT clocks.
//     After WIDTH bits -> PARITY if PARITY_EN, else STOP.
//   - PARITY serial_out=^data (even parity) for CLKS_PER_BIT clocks -> STOP.
//   - STOP   serial_out=1 for STOP_BITS*CLKS_PER_BIT clocks -> IDLE.
//     done=1 in the first IDLE cycle.
// - Bit timer: counts 0..CLKS_PER_BIT-1. Tick at terminal count advances bit/state; reloads to 0.
// - Frame length: (1+WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT clocks.
// - Inter-frame gap: minimum 1 IDLE cycle. tx_ready=1 in the same cycle as done.
//   A word presented then is accepted at the next edge.
// - tx_valid while busy: ignored, no queueing. tx_data changes while busy: no effect.
// - Reset mid-frame: frame abandoned, no done pulse, serial_out=1 the cycle after the reset edge.
// - Counter widths: bit index $clog2(WIDTH+1); timer $clog2(CLKS_PER_BIT+1). No wrap beyond terminal count.
// STRUCTURE
// - Include file serial_frame_defs.vh: state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4),
//   LINE_IDLE=1'b1, START_LEVEL=1'b0.
// - Shared with the matching receiver.
// - One sub-module: bit_timer (CLKS_PER_BIT counter; inputs clock, reset, run; output tick).
// - FSM, shift register, parity and bit counter stay in serial_frame_tx.
// TESTING (WIDTH=8, CLKS_PER_BIT=2, PARITY_EN=1, STOP_BITS=1; 22-clock frame)
// - Reset held 3 clocks, then released
//   -> serial_out=1, tx_ready=1, busy=0, done=0 throughout.
// - Send 8'hA5
//   -> serial_out 0,1,0,1,0,0,1,0,1,0(par),1, each bit 2 clocks.
//   -> done pulses exactly 22 clocks after the first serial_out=0 cycle.
// - Send 8'h07 (odd number of ones) -> parity bit=1. Send 8'h00 -> parity bit=0, data bits all 0.
// - Back-to-back: tx_valid held 1 with 8'h3C then 8'hC3
//   -> second START begins 1 cycle after done. Exactly 1 idle-high cycle between frames.
// - tx_valid pulsed with 8'hFF mid-frame -> ignored; the current frame is unchanged and no extra frame is sent.
// - reset asserted during DATA bit 4 -> serial_out=1, tx_ready=1 next cycle.
//   -> No done. The next accepted word is sent cleanly.

Source files
------------

// File: rtl/serial_frame_tx_pkg.sv
// serial_frame_tx_pkg: state encodings and line levels shared by the
// serial frame transmitter and the matching receiver.
package serial_frame_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// bit_timer: counts 0..CLKS_PER_BIT-1 while run is high.
// Ports: clock, reset (sync, high), run in; tick out at terminal count.
module bit_timer #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] TERM = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] r_cnt;

  assign tick = run && (r_cnt == TERM);

  // Held at 0 while idle so every frame starts a fresh bit period.
  always_ff @(posedge clock) begin
    if (reset || !run || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: start bit, WIDTH data bits LSB first, optional even
// parity, STOP_BITS stop bits. Ports: clock, reset, tx_data/valid/ready,
// serial_out (idle 1), busy, done (1-cycle pulse after last stop bit).
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 2,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  import serial_frame_tx_pkg::*;

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_par;
  logic [BW-1:0]    r_bit;
  logic             w_tick;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .run  (busy),
    .tick (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_par      <= 1'b0;
      r_bit      <= '0;
      serial_out <= LINE_IDLE;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (tx_valid && tx_ready) begin
            r_shreg    <= tx_data;
            r_par      <= ^tx_data;
            r_state    <= S_START;
            serial_out <= START_LEVEL;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_state    <= S_DATA;
            serial_out <= r_shreg[0];
            r_bit      <= '0;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_bit == LAST_DATA) begin
              r_bit <= '0;
              if (PARITY_EN != 0) begin
                r_state    <= S_PARITY;
                serial_out <= r_par;
              end else begin
                r_state    <= S_STOP;
                serial_out <= LINE_IDLE;
              end
            end else begin
              // Old bit 1 becomes the next bit on the line.
              r_bit      <= r_bit + 1'b1;
              r_shreg    <= r_shreg >> 1;
              serial_out <= r_shreg[1];
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_state    <= S_STOP;
            serial_out <= LINE_IDLE;
            r_bit      <= '0;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_bit == LAST_STOP) begin
              r_state  <= S_IDLE;
              r_bit    <= '0;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          serial_out <= LINE_IDLE;
          tx_ready   <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed frame checks for serial_frame_tx
// (WIDTH=8, CLKS_PER_BIT=2, PARITY_EN=1, STOP_BITS=1, 22-clock frame).
module tb_serial_frame_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       serial_out;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  serial_frame_tx #(
    .WIDTH       (8),
    .CLKS_PER_BIT(2),
    .PARITY_EN   (1),
    .STOP_BITS   (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .serial_out(serial_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  // Called at the negedge of the first START cycle. Walks the 22 frame
  // cycles (exp bit k = k-th serial bit, each held 2 clocks) and ends at
  // the negedge of the done cycle. glitch>=0 pulses tx_valid with 8'hFF.
  task automatic watch_frame(input string nm, input logic [10:0] exp,
                             input int glitch);
    for (int c = 0; c < 22; c++) begin
      n_cmp++;
      if (serial_out !== exp[c/2]) begin
        n_err++;
        $display("FAIL %s serial c=%0d got=%b want=%b", nm, c, serial_out, exp[c/2]);
      end
      n_cmp++;
      if ({busy, tx_ready, done} !== 3'b100) begin
        n_err++;
        $display("FAIL %s busy/ready/done c=%0d got=%b want=100", nm, c,
                 {busy, tx_ready, done});
      end
      if (c == glitch) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end else if (glitch >= 0 && c == glitch + 1) begin
        tx_valid = 1'b0;
      end
      @(negedge clock);
    end
    n_cmp++;
    if ({serial_out, busy, tx_ready, done} !== 4'b1011) begin
      n_err++;
      $display("FAIL %s done_cycle got=%b want=1011", nm,
               {serial_out, busy, tx_ready, done});
    end
  endtask

  task automatic start_word(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({serial_out, tx_ready, busy, done} !== 4'b1100) begin
        n_err++;
        $display("FAIL reset_hold i=%0d got=%b want=1100", i,
                 {serial_out, tx_ready, busy, done});
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({serial_out, tx_ready, busy, done} !== 4'b1100) begin
        n_err++;
        $display("FAIL reset_idle i=%0d got=%b want=1100", i,
                 {serial_out, tx_ready, busy, done});
      end
    end
  endtask

  task automatic test_a5();
    start_word(8'hA5);
    watch_frame("a5", 11'b10101001010, -1);
    @(negedge clock);
    n_cmp++;
    if ({serial_out, done, tx_ready} !== 3'b101) begin
      n_err++;
      $display("FAIL a5_after got=%b want=101", {serial_out, done, tx_ready});
    end
  endtask

  task automatic test_parity();
    start_word(8'h07);
    watch_frame("x07", 11'b11000001110, -1);
    @(negedge clock);
    start_word(8'h00);
    watch_frame("x00", 11'b10000000000, -1);
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(negedge clock);
    tx_data = 8'hC3;
    watch_frame("b2b_3c", 11'b10001111000, -1);
    @(negedge clock);
    tx_valid = 1'b0;
    watch_frame("b2b_c3", 11'b10110000110, -1);
    @(negedge clock);
  endtask

  task automatic test_busy_ignore();
    start_word(8'hA5);
    watch_frame("ign_a5", 11'b10101001010, 8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({serial_out, busy, tx_ready} !== 3'b101) begin
        n_err++;
        $display("FAIL ign_noframe i=%0d got=%b want=101", i,
                 {serial_out, busy, tx_ready});
      end
    end
  endtask

  task automatic test_reset_mid();
    start_word(8'h5A);
    // Data bit 4 occupies frame cycles 10 and 11.
    for (int c = 0; c < 10; c++) @(negedge clock);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_busy got=%b want=1", busy);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_cmp++;
    if ({serial_out, tx_ready, busy, done} !== 4'b1100) begin
      n_err++;
      $display("FAIL rmid_after got=%b want=1100",
               {serial_out, tx_ready, busy, done});
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      n_cmp++;
      if ({serial_out, done} !== 2'b10) begin
        n_err++;
        $display("FAIL rmid_nodone i=%0d got=%b want=10", i, {serial_out, done});
      end
    end
    start_word(8'h07);
    watch_frame("rmid_x07", 11'b11000001110, -1);
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_a5();
    test_parity();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
